reg_wb_arbiter: RTL and testbench



---
 rtl/reg_wb_arbiter.sv | 88 ++++++++
 tb/tb_reg_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs. memory load) for the 4 x 8-bit register group,
// with a per-register busy scoreboard for destination reservation and RAW stalls.
module reg_wb_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       rsv_valid,
    input  logic [1:0] rsv_dr,
    output logic       rsv_ok,
    input  logic       a_valid,
    input  logic [1:0] a_dr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       m_valid,
    input  logic [1:0] m_dr,
    input  logic [7:0] m_data,
    output logic       m_ready,
    output logic       rf_we,
    output logic [1:0] rf_dr,
    output logic [7:0] rf_i,
    output logic [3:0] busy,
    output logic       wb_err,
    output logic [7:0] wr_cnt
);

    localparam int unsigned NREG = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 8;

    logic            last_m;
    logic            xfer;
    logic            win_m;
    logic [IW-1:0]   win_dr;
    logic [DW-1:0]   win_data;
    logic [NREG-1:0] busy_nxt;

    // Grant: last_m set means M won last time, so A wins the next contention.
    always_comb begin
        rsv_ok   = ~busy[rsv_dr] & ~flush;
        a_ready  = ~flush & a_valid & (~m_valid | last_m);
        m_ready  = ~flush & m_valid & (~a_valid | ~last_m);
        win_m    = m_valid & m_ready;
        xfer     = (a_valid & a_ready) | win_m;
        win_dr   = win_m ? m_dr : a_dr;
        win_data = win_m ? m_data : a_data;
    end

    // Scoreboard: flush dominates, then clear the written register, then reserve.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (xfer) begin
                busy_nxt[win_dr] = 1'b0;
            end
            if (rsv_valid && rsv_ok) begin
                busy_nxt[rsv_dr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we  <= 1'b0;
            rf_dr  <= '0;
            rf_i   <= '0;
            busy   <= '0;
            wb_err <= 1'b0;
            wr_cnt <= '0;
            last_m <= 1'b1;
        end else begin
            rf_we <= xfer;
            busy  <= busy_nxt;
            if (xfer) begin
                rf_dr  <= win_dr;
                rf_i   <= win_data;
                wr_cnt <= CW'(wr_cnt + CW'(1));
                last_m <= win_m;
                if (!busy[win_dr]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reservation, round-robin grants, flush,
// sticky error flag, write-counter wrap and mid-burst reset.
module tb_reg_wb_arbiter;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       rsv_valid;
    logic [1:0] rsv_dr;
    logic       rsv_ok;
    logic       a_valid;
    logic [1:0] a_dr;
    logic [7:0] a_data;
    logic       a_ready;
    logic       m_valid;
    logic [1:0] m_dr;
    logic [7:0] m_data;
    logic       m_ready;
    logic       rf_we;
    logic [1:0] rf_dr;
    logic [7:0] rf_i;
    logic [3:0] busy;
    logic       wb_err;
    logic [7:0] wr_cnt;

    int n_cmp;
    int n_mis;

    logic [7:0] rf_model [4];

    reg_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rsv_valid (rsv_valid),
        .rsv_dr    (rsv_dr),
        .rsv_ok    (rsv_ok),
        .a_valid   (a_valid),
        .a_dr      (a_dr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .m_valid   (m_valid),
        .m_dr      (m_dr),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .rf_we     (rf_we),
        .rf_dr     (rf_dr),
        .rf_i      (rf_i),
        .busy      (busy),
        .wb_err    (wb_err),
        .wr_cnt    (wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register group: samples the write port on the falling edge.
    always @(negedge clk) begin
        if (rf_we === 1'b1) rf_model[rf_dr] <= rf_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        flush = 1'b0; rsv_valid = 1'b0; rsv_dr = 2'd0;
        a_valid = 1'b0; a_dr = 2'd0; a_data = 8'h00;
        m_valid = 1'b0; m_dr = 2'd0; m_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rf_we",  32'(rf_we),  32'(0));
        chk("rst_rf_dr",  32'(rf_dr),  32'(0));
        chk("rst_rf_i",   32'(rf_i),   32'(0));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_wb_err", 32'(wb_err), 32'(0));
        chk("rst_wr_cnt", 32'(wr_cnt), 32'(0));
        #10 rst_n = 1'b1;
        tick;

        // Reserve r2, then A writes r2 = 5A.
        rsv_valid = 1'b1; rsv_dr = 2'd2;
        #1 chk("rsv2_ok", 32'(rsv_ok), 32'(1));
        tick;
        rsv_valid = 1'b0;
        chk("rsv2_busy", 32'(busy), 32'(4'b0100));
        a_valid = 1'b1; a_dr = 2'd2; a_data = 8'h5A;
        #1 chk("a1_ready", 32'(a_ready), 32'(1));
        tick;
        chk("a1_busy",   32'(busy),   32'(0));
        chk("a1_we",     32'(rf_we),  32'(1));
        chk("a1_dr",     32'(rf_dr),  32'(2));
        chk("a1_i",      32'(rf_i),   32'(8'h5A));
        chk("a1_cnt",    32'(wr_cnt), 32'(1));
        chk("a1_err",    32'(wb_err), 32'(0));
        a_valid = 1'b0;
        #5 chk("a1_rfread", 32'(rf_model[2]), 32'(8'h5A));
        tick;
        chk("a1_we_drop", 32'(rf_we), 32'(0));

        // Reserved M write to r1 so that M holds the round-robin pointer.
        rsv_valid = 1'b1; rsv_dr = 2'd1;
        tick;
        rsv_valid = 1'b0;
        m_valid = 1'b1; m_dr = 2'd1; m_data = 8'h33;
        #1 chk("m1_ready", 32'(m_ready), 32'(1));
        tick;
        m_valid = 1'b0;
        chk("m1_dr",  32'(rf_dr),  32'(1));
        chk("m1_i",   32'(rf_i),   32'(8'h33));
        chk("m1_cnt", 32'(wr_cnt), 32'(2));
        chk("m1_err", 32'(wb_err), 32'(0));

        // Contention: A r0=11 vs M r1=22, re-reserving as each write retires.
        rsv_valid = 1'b1; rsv_dr = 2'd0;
        tick;
        rsv_dr = 2'd1;
        tick;
        rsv_valid = 1'b0;
        chk("ct_busy0", 32'(busy), 32'(4'b0011));
        a_valid = 1'b1; a_dr = 2'd0; a_data = 8'h11;
        m_valid = 1'b1; m_dr = 2'd1; m_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            rsv_valid = (i == 1) || (i == 2);
            rsv_dr    = (i == 1) ? 2'd0 : 2'd1;
            #1;
            chk("ct_a_ready", 32'(a_ready), 32'((i % 2) == 0));
            chk("ct_m_ready", 32'(m_ready), 32'((i % 2) == 1));
            if (rsv_valid) chk("ct_rsv_ok", 32'(rsv_ok), 32'(1));
            tick;
            chk("ct_we", 32'(rf_we), 32'(1));
            chk("ct_dr", 32'(rf_dr), 32'(((i % 2) == 0) ? 0 : 1));
            chk("ct_i",  32'(rf_i),  32'(((i % 2) == 0) ? 8'h11 : 8'h22));
        end
        a_valid = 1'b0; m_valid = 1'b0; rsv_valid = 1'b0;
        chk("ct_cnt",  32'(wr_cnt), 32'(6));
        chk("ct_busy", 32'(busy),   32'(0));
        chk("ct_err",  32'(wb_err), 32'(0));

        // Reserve r3 refused while its write is being accepted; retry succeeds.
        rsv_valid = 1'b1; rsv_dr = 2'd3;
        tick;
        chk("r3_we_idle", 32'(rf_we), 32'(0));
        chk("r3_busy",    32'(busy),  32'(4'b1000));
        a_valid = 1'b1; a_dr = 2'd3; a_data = 8'h77;
        #1;
        chk("r3_rsv_ok0", 32'(rsv_ok),  32'(0));
        chk("r3_a_ready", 32'(a_ready), 32'(1));
        tick;
        a_valid = 1'b0;
        chk("r3_busy_clr", 32'(busy),   32'(0));
        chk("r3_err",      32'(wb_err), 32'(0));
        chk("r3_cnt",      32'(wr_cnt), 32'(7));
        #1 chk("r3_rsv_ok1", 32'(rsv_ok), 32'(1));
        tick;
        chk("r3_busy_set", 32'(busy), 32'(4'b1000));
        rsv_dr = 2'd0;
        tick;
        rsv_dr = 2'd1;
        tick;
        rsv_valid = 1'b0;
        chk("fl_busy_pre", 32'(busy), 32'(4'b1011));

        // Flush blocks the grant and reservations and clears the scoreboard.
        flush = 1'b1; rsv_valid = 1'b1; rsv_dr = 2'd2;
        a_valid = 1'b1; a_dr = 2'd0; a_data = 8'h44;
        #1;
        chk("fl_a_ready", 32'(a_ready), 32'(0));
        chk("fl_rsv_ok",  32'(rsv_ok),  32'(0));
        tick;
        chk("fl_busy", 32'(busy),   32'(0));
        chk("fl_we",   32'(rf_we),  32'(0));
        chk("fl_cnt",  32'(wr_cnt), 32'(7));
        flush = 1'b0; rsv_valid = 1'b0;
        #1 chk("fl_a_ready2", 32'(a_ready), 32'(1));
        tick;
        a_valid = 1'b0;
        chk("fl_we2",  32'(rf_we),  32'(1));
        chk("fl_i2",   32'(rf_i),   32'(8'h44));
        chk("fl_err",  32'(wb_err), 32'(1));
        chk("fl_cnt2", 32'(wr_cnt), 32'(8));

        // A clean reserved write leaves the error flag set.
        rsv_valid = 1'b1; rsv_dr = 2'd1;
        tick;
        rsv_valid = 1'b0;
        m_valid = 1'b1; m_dr = 2'd1; m_data = 8'h99;
        tick;
        m_valid = 1'b0;
        chk("st_i",   32'(rf_i),   32'(8'h99));
        chk("st_err", 32'(wb_err), 32'(1));
        chk("st_cnt", 32'(wr_cnt), 32'(9));

        // Burst of A writes up to the counter wrap.
        a_valid = 1'b1; a_dr = 2'd0; a_data = 8'hC3;
        for (int i = 0; i < 246; i++) tick;
        chk("wr_cnt_ff", 32'(wr_cnt), 32'(8'hFF));
        tick;
        chk("wr_cnt_wrap", 32'(wr_cnt), 32'(0));
        chk("burst_we",    32'(rf_we),  32'(1));

        // M contends after an A win, then reset lands mid-burst.
        m_valid = 1'b1; m_dr = 2'd1; m_data = 8'hE1;
        #1;
        chk("pre_rst_m_ready", 32'(m_ready), 32'(1));
        chk("pre_rst_a_ready", 32'(a_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("rst2_we",      32'(rf_we),   32'(0));
        chk("rst2_cnt",     32'(wr_cnt),  32'(0));
        chk("rst2_err",     32'(wb_err),  32'(0));
        chk("rst2_a_ready", 32'(a_ready), 32'(1));
        chk("rst2_m_ready", 32'(m_ready), 32'(0));
        rst_n = 1'b1;
        tick;
        chk("post_rst_we",  32'(rf_we),  32'(1));
        chk("post_rst_dr",  32'(rf_dr),  32'(0));
        chk("post_rst_i",   32'(rf_i),   32'(8'hC3));
        chk("post_rst_cnt", 32'(wr_cnt), 32'(1));
        chk("post_rst_err", 32'(wb_err), 32'(1));
        a_valid = 1'b0; m_valid = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
